// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the CORDIC sequencer
//
// Purpose:
//   Holds the sequencer state encoding, the iteration index width, and the
//   upper bound on micro-rotations. It also provides a helper that turns an
//   iteration count into the index of the final iteration.
// Ports: none (package)
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } cordic_state_e;

  localparam int ITER_W   = 5;
  localparam int MAX_ITER = 32;

  // Index of the final micro-rotation for a given count. The count is
  // clamped into 1..MAX_ITER so that an out-of-range parameter cannot
  // produce an index the counter never reaches.
  function automatic logic [ITER_W-1:0] last_iter_idx(input int cnt);
    int c;
    c = cnt;
    if (c < 1)        c = 1;
    if (c > MAX_ITER) c = MAX_ITER;
    return ITER_W'(c - 1);
  endfunction

endpackage

// File: rtl/param_reg.sv
// rtl/param_reg.sv - parameterised enable register with synchronous reset
//
// Purpose:
//   A plain WIDTH-bit hold register. It loads i_d when i_en is high and
//   clears on rst.
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset (clears o_q)
//   i_en  in   1      load enable
//   i_d   in   WIDTH  data in
//   o_q   out  WIDTH  held data
module param_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - control sequencer for an iterative CORDIC datapath
//
// Purpose:
//   Accepts one operand set through in_valid/in_ready. It then steps the
//   datapath through ITERATION_CNT feedback cycles and captures the scaled
//   x/y result. The result is held under out_valid/out_ready. The datapath's
//   mux select, register enable and iteration index are all driven from here.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      requester presents operands on the datapath inputs
//   in_ready   out  1      operands accepted this cycle (combinational in DONE)
//   mux_ctrl   out  1      0 = external operands, 1 = add/sub feedback
//   reg_en     out  1      datapath x/y/z register enable
//   iter_o     out  5      iteration index (shift amount / atan address)
//   x_res_i    in   WIDTH  datapath x scaler output
//   y_res_i    in   WIDTH  datapath y scaler output
//   out_valid  out  1      x_res_o/y_res_o hold a completed result
//   out_ready  in   1      consumer takes the result
//   x_res_o    out  WIDTH  held x result
//   y_res_o    out  WIDTH  held y result
//   busy       out  1      high while iterating
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ITERATION_CNT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mux_ctrl,
  output logic              reg_en,
  output logic [ITER_W-1:0] iter_o,
  input  logic [WIDTH-1:0]  x_res_i,
  input  logic [WIDTH-1:0]  y_res_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  x_res_o,
  output logic [WIDTH-1:0]  y_res_o,
  output logic              busy
);

  localparam logic [ITER_W-1:0] LP_LAST = last_iter_idx(ITERATION_CNT);

  cordic_state_e     r_state;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_mux;
  logic              r_out_valid;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_capture;

  assign w_last    = (r_iter == LP_LAST);
  assign w_capture = (r_state == ITER) && w_last;

  // In DONE the controller can take new operands only in the same cycle the
  // held result is retired. That makes in_ready follow out_ready directly.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      IDLE:    w_in_ready = 1'b1;
      DONE:    w_in_ready = out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = w_in_ready & in_valid;

  // The datapath registers load on every accept (mux = external operands)
  // and on every feedback cycle.
  assign reg_en = (r_state == ITER) | w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_iter      <= '0;
      r_busy      <= 1'b0;
      r_mux       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= ITER;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_mux   <= 1'b1;
          end
        end
        ITER: begin
          if (w_last) begin
            r_state     <= DONE;
            r_iter      <= '0;
            r_busy      <= 1'b0;
            r_mux       <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_iter <= r_iter + ITER_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_state <= ITER;
              r_iter  <= '0;
              r_busy  <= 1'b1;
              r_mux   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_iter      <= '0;
          r_busy      <= 1'b0;
          r_mux       <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The result registers load only on the final iteration, so they keep the
  // last result across retire and IDLE until the next capture or reset.
  param_reg #(.WIDTH(WIDTH)) u_x_hold (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_capture),
    .i_d  (x_res_i),
    .o_q  (x_res_o)
  );

  param_reg #(.WIDTH(WIDTH)) u_y_hold (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_capture),
    .i_d  (y_res_i),
    .o_q  (y_res_o)
  );

  assign in_ready  = w_in_ready;
  assign mux_ctrl  = r_mux;
  assign iter_o    = r_iter;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb/tb_cordic_seq_ctrl.sv - self-checking bench for cordic_seq_ctrl
module tb_cordic_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // instance 0: ITERATION_CNT=6, instance 1: ITERATION_CNT=1
  logic        rst0, iv0, or0, ir0, mux0, re0, ov0, busy0;
  logic [4:0]  it0;
  logic [15:0] xi0, yi0, xo0, yo0;
  logic        rst1, iv1, or1, ir1, mux1, re1, ov1, busy1;
  logic [4:0]  it1;
  logic [15:0] xi1, yi1, xo1, yo1;

  cordic_seq_ctrl #(.WIDTH(16), .ITERATION_CNT(6)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .mux_ctrl(mux0),
    .reg_en(re0), .iter_o(it0), .x_res_i(xi0), .y_res_i(yi0), .out_valid(ov0),
    .out_ready(or0), .x_res_o(xo0), .y_res_o(yo0), .busy(busy0)
  );

  cordic_seq_ctrl #(.WIDTH(16), .ITERATION_CNT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .mux_ctrl(mux1),
    .reg_en(re1), .iter_o(it1), .x_res_i(xi1), .y_res_i(yi1), .out_valid(ov1),
    .out_ready(or1), .x_res_o(xo1), .y_res_o(yo1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        iv, orr;
    logic [15:0] x, y;
    logic        e_ir, e_mux, e_re;
    logic [4:0]  e_it;
    logic        e_ov, e_busy;
    logic [15:0] e_xo, e_yo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input logic orr, input logic [15:0] x,
                              input logic [15:0] y, input logic ir, input logic mx,
                              input logic re, input logic [4:0] it, input logic ov,
                              input logic bz, input logic [15:0] xo, input logic [15:0] yo);
    vec_t v;
    v.iv = iv; v.orr = orr; v.x = x; v.y = y;
    v.e_ir = ir; v.e_mux = mx; v.e_re = re; v.e_it = it;
    v.e_ov = ov; v.e_busy = bz; v.e_xo = xo; v.e_yo = yo;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // A transaction view: the cycle an operation was accepted, whether a result is
  // held, and the last captured values. Expected outputs follow from the cycle
  // distance to the accept.
  int          cyc;
  int          m_acc [2];
  bit          m_hold[2];
  logic [15:0] m_rx  [2];
  logic [15:0] m_ry  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = -1; m_hold[i] = 1'b0; m_rx[i] = '0; m_ry[i] = '0;
    end
  endtask

  task automatic model_step(input int i, input int cnt, input logic rst, input logic iv,
                            input logic orr, input logic [15:0] x, input logic [15:0] y,
                            input logic ir, input logic mx, input logic re,
                            input logic [4:0] it, input logic ov, input logic bz,
                            input logic [15:0] xo, input logic [15:0] yo);
    bit         iter_ph;
    logic       e_ir, e_mux, e_re, e_ov, e_bz;
    logic [4:0] e_it;
    iter_ph = (m_acc[i] >= 0) && (cyc > m_acc[i]) && (cyc <= m_acc[i] + cnt);
    if (iter_ph) begin
      e_ir = 0; e_mux = 1; e_re = 1; e_it = 5'(cyc - m_acc[i] - 1); e_ov = 0; e_bz = 1;
    end else if (m_hold[i]) begin
      e_ir = orr; e_mux = 0; e_re = orr & iv; e_it = 0; e_ov = 1; e_bz = 0;
    end else begin
      e_ir = 1; e_mux = 0; e_re = iv; e_it = 0; e_ov = 0; e_bz = 0;
    end
    check($sformatf("rnd%0d in_ready", i), ir, e_ir);
    check($sformatf("rnd%0d mux_ctrl", i), mx, e_mux);
    check($sformatf("rnd%0d reg_en", i), re, e_re);
    check($sformatf("rnd%0d iter_o", i), it, e_it);
    check($sformatf("rnd%0d out_valid", i), ov, e_ov);
    check($sformatf("rnd%0d busy", i), bz, e_bz);
    check($sformatf("rnd%0d x_res_o", i), xo, m_rx[i]);
    check($sformatf("rnd%0d y_res_o", i), yo, m_ry[i]);
    // state advance at the coming edge
    if (rst) begin
      m_acc[i] = -1; m_hold[i] = 0; m_rx[i] = '0; m_ry[i] = '0;
    end else if (iter_ph) begin
      if (cyc == m_acc[i] + cnt) begin
        m_hold[i] = 1; m_rx[i] = x; m_ry[i] = y; m_acc[i] = -1;
      end
    end else if (e_ir && iv) begin
      m_acc[i] = cyc; m_hold[i] = 0;
    end else if (m_hold[i] && orr) begin
      m_hold[i] = 0;
    end
  endtask

  task automatic reset0();
    rst0 = 1; iv0 = 0; or0 = 0; xi0 = '0; yi0 = '0;
    next_cycle();
    next_cycle();
    rst0 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst0 = 1; iv0 = 0; or0 = 0; xi0 = '0; yi0 = '0;
    rst1 = 1; iv1 = 0; or1 = 0; xi1 = '0; yi1 = '0;

    // ---- test 1: reset state ----
    next_cycle();
    next_cycle();
    rst0 = 0;
    @(negedge clk);
    check("rst in_ready", ir0, 1);
    check("rst out_valid", ov0, 0);
    check("rst iter_o", it0, 0);
    check("rst reg_en", re0, 0);
    check("rst x_res_o", xo0, 0);
    check("rst y_res_o", yo0, 0);
    check("rst busy", busy0, 0);
    check("rst mux_ctrl", mux0, 0);

    // ---- tests 2/3: single op then backpressure, table-driven ----
    tbl.push_back(mk(1, 0, 16'h1111, 16'h1111, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h2222, 16'h2222, 0, 1, 1, 0, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h3333, 16'h3333, 0, 1, 1, 1, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h4444, 16'h4444, 0, 1, 1, 2, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h5555, 16'h5555, 0, 1, 1, 3, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'hDEAD, 16'hBEEF, 0, 1, 1, 4, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h1234, 16'h0ABC, 0, 1, 1, 5, 0, 1, 16'h0000, 16'h0000));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1, 0, 16'h1234, 16'h0ABC));
    tbl.push_back(mk(0, 1, 16'hEEEE, 16'hEEEE, 1, 0, 0, 0, 1, 0, 16'h1234, 16'h0ABC));
    tbl.push_back(mk(0, 0, 16'h7777, 16'h7777, 1, 0, 0, 0, 0, 0, 16'h1234, 16'h0ABC));

    foreach (tbl[k]) begin
      next_cycle();
      iv0 = tbl[k].iv; or0 = tbl[k].orr; xi0 = tbl[k].x; yi0 = tbl[k].y;
      @(negedge clk);
      check($sformatf("tbl%0d in_ready", k), ir0, tbl[k].e_ir);
      check($sformatf("tbl%0d mux_ctrl", k), mux0, tbl[k].e_mux);
      check($sformatf("tbl%0d reg_en", k), re0, tbl[k].e_re);
      check($sformatf("tbl%0d iter_o", k), it0, tbl[k].e_it);
      check($sformatf("tbl%0d out_valid", k), ov0, tbl[k].e_ov);
      check($sformatf("tbl%0d busy", k), busy0, tbl[k].e_busy);
      check($sformatf("tbl%0d x_res_o", k), xo0, tbl[k].e_xo);
      check($sformatf("tbl%0d y_res_o", k), yo0, tbl[k].e_yo);
    end

    // ---- test 4: back-to-back ----
    reset0();
    iv0 = 1; or0 = 1;
    for (int k = 0; k < 30; k++) begin
      xi0 = 16'(k * 16'h0101);
      @(negedge clk);
      check($sformatf("b2b%0d out_valid", k), ov0, (k > 0 && k % 7 == 0) ? 1 : 0);
      if (k > 0 && k % 7 == 0) check($sformatf("b2b%0d in_ready", k), ir0, 1);
      next_cycle();
    end
    iv0 = 0;

    // ---- test 5: reset mid-operation ----
    reset0();
    iv0 = 1;
    next_cycle();
    iv0 = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (busy0 === 1'b1 && it0 === 5'd3) found = 1;
      else next_cycle();
    end
    check("midop reached iter 3", found, 1);
    rst0 = 1;
    next_cycle();
    rst0 = 0; or0 = 1;
    @(negedge clk);
    check("midop iter_o", it0, 0);
    check("midop busy", busy0, 0);
    check("midop in_ready", ir0, 1);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("midop%0d out_valid", k), ov0, 0);
      next_cycle();
      @(negedge clk);
    end

    // ---- test 6: ITERATION_CNT=1 ----
    next_cycle();
    rst1 = 0; iv1 = 1; or1 = 0;
    @(negedge clk);
    check("c1 k0 in_ready", ir1, 1);
    check("c1 k0 reg_en", re1, 1);
    check("c1 k0 mux_ctrl", mux1, 0);
    next_cycle();
    iv1 = 0; xi1 = 16'hBEEF; yi1 = 16'h0123;
    @(negedge clk);
    check("c1 k1 busy", busy1, 1);
    check("c1 k1 iter_o", it1, 0);
    check("c1 k1 mux_ctrl", mux1, 1);
    check("c1 k1 out_valid", ov1, 0);
    next_cycle();
    xi1 = 16'h0000; yi1 = 16'h0000;
    @(negedge clk);
    check("c1 k2 out_valid", ov1, 1);
    check("c1 k2 x_res_o", xo1, 16'hBEEF);
    check("c1 k2 y_res_o", yo1, 16'h0123);
    check("c1 k2 busy", busy1, 0);

    // ---- randomized run against the model, both instances ----
    rst0 = 1; rst1 = 1; iv0 = 0; iv1 = 0; or0 = 0; or1 = 0;
    next_cycle();
    next_cycle();
    model_reset();
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      rst0 = ($urandom_range(0, 63) == 0);
      rst1 = ($urandom_range(0, 63) == 0);
      iv0 = ($urandom_range(0, 3) != 0);
      iv1 = ($urandom_range(0, 1) != 0);
      or0 = ($urandom_range(0, 2) != 0);
      or1 = ($urandom_range(0, 3) == 0);
      xi0 = 16'($urandom); yi0 = 16'($urandom);
      xi1 = 16'($urandom); yi1 = 16'($urandom);
      @(negedge clk);
      model_step(0, 6, rst0, iv0, or0, xi0, yi0, ir0, mux0, re0, it0, ov0, busy0, xo0, yo0);
      model_step(1, 1, rst1, iv1, or1, xi1, yi1, ir1, mux1, re1, it1, ov1, busy1, xo1, yo1);
      cyc++;
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
